// File: rtl/inst_queue_pkg.sv
// Shared CPU constants for fetch, decode and ROB.
// Holds the queue geometry and the fetch entry layout.
package inst_queue_pkg;

  localparam int XLEN       = 32;
  localparam int IQ_DEPTH   = 16;
  localparam int IQ_ADDR_W  = 4;
  localparam int IQ_ENTRY_W = 2 * XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue.
// Circular buffer with show-ahead head and flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int ADDR_W = IQ_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [XLEN-1:0]   if_inst,
  output logic              iq_full,
  input  logic              dec_ready,
  output logic              iq_valid,
  output logic [XLEN-1:0]   iq_pc,
  output logic [XLEN-1:0]   iq_inst,
  output logic [ADDR_W:0]   iq_count
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  iq_entry_t         mem [DEPTH];
  iq_entry_t         head_e;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic              push;
  logic              pop;

  // Flags come from the start-of-cycle count only.
  assign iq_full  = (count == FULL_CNT);
  assign iq_valid = (count != '0);
  assign iq_count = count;

  assign push = rdy && !clr && if_valid && !iq_full;
  assign pop  = rdy && !clr && dec_ready && iq_valid;

  // Show-ahead head read straight from storage.
  assign head_e  = mem[head];
  assign iq_pc   = head_e.pc;
  assign iq_inst = head_e.inst;

  // Entry storage; not reset, written on accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{pc: if_pc, inst: if_inst};
    end
  end

  // Pointer and occupancy update; flush beats handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (clr) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        unique case (1'b1)
          push && !pop: count <= count + CNT_ONE;
          pop && !push: count <= count - CNT_ONE;
          default:      count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_W, default 4, log2(DEPTH) pointer width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rdy  input  1  global enable; when 0, all state holds.
REQ-006 clr  input  1  flush from ROB on mispredict/jump.
REQ-007 if_valid  input  1  fetch stage offers an instruction.
REQ-008 if_pc  input  32  PC of offered instruction.
REQ-009 if_inst  input  32  offered instruction word.
REQ-010 iq_full  output  1  queue full, registered; fetch stalls while 1.
REQ-011 dec_ready  input  1  decoder consumes the head this cycle.
REQ-012 iq_valid  output  1  head entry present (queue not empty).
REQ-013 iq_pc  output  32  head PC, show-ahead.
REQ-014 iq_inst  output  32  head instruction, show-ahead.
REQ-015 iq_count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Function
REQ-016 Circular buffer of DEPTH {pc, inst} entries; head and tail pointers of ADDR_W bits wrap modulo DEPTH.
REQ-017 Push when rdy && !clr && if_valid && !iq_full: write {if_pc, if_inst} at tail, tail+1.
REQ-018 Pop when rdy && !clr && dec_ready && iq_valid: head+1.
REQ-019 Push and pop in the same cycle SHALL both occur; count unchanged.
REQ-020 Push offered while iq_full=1 SHALL be dropped, no state change; iq_full reflects start-of-cycle count, so push is refused on a full queue even if a pop occurs that cycle.
REQ-021 Pop requested while empty SHALL be ignored.
REQ-022 iq_full = (count == DEPTH); iq_valid = (count != 0); both derived from registered count.
REQ-023 iq_pc/iq_inst SHALL present the head entry combinationally from storage; value is don't-care when iq_valid=0.
REQ-024 Push-to-visible latency: an entry pushed into an empty queue SHALL show iq_valid=1 the following cycle.
REQ-025 clr (with rdy=1) SHALL set head=tail=0, count=0 at next edge; same-cycle push/pop discarded; clr has priority over everything except reset.
REQ-026 clr while rdy=0 SHALL be ignored.
REQ-027 count arithmetic in ADDR_W+1 bits; never exceeds DEPTH nor underflows.

Reset
REQ-028 On rst=0, asynchronously: head=0, tail=0, count=0, iq_full=0, iq_valid=0, iq_count=0.
REQ-029 Storage array SHALL NOT be reset; iq_pc/iq_inst undefined until first push.
REQ-030 Reset asserted mid-operation SHALL discard all entries regardless of rdy, clr, or handshakes.

Structure
REQ-031 DEPTH, ADDR_W, PC/instruction width (32) and entry width (64) SHALL live in the shared CPU constants package used by fetch, decoder and ROB.
REQ-032 Single module; no sub-module; storage as a register array.

Verification
REQ-033 Reset then push PC 0x0,0x4,0x8 (insts 0x00000013, 0x00100093, 0x00200113), dec_ready=0 -> iq_count=3, iq_pc=0x0, iq_inst=0x00000013.
REQ-034 Push 16 entries, dec_ready=0 -> iq_full=1 after 16th; 17th push (PC 0x40) dropped; popping all returns PCs 0x0..0x3C in order.
REQ-035 Full queue, if_valid=1 and dec_ready=1 same cycle -> head pops, push refused, iq_count=15; next cycle push accepted, iq_count=16.
REQ-036 Count 5, assert clr with if_valid=1 and dec_ready=1 -> next cycle iq_count=0, iq_valid=0; new push PC 0x100 then visible at head.
REQ-037 rdy=0 for 3 cycles with if_valid=1, dec_ready=1, clr=1 -> count, pointers, outputs unchanged.
REQ-038 Drive rst=0 asynchronously between edges with count 7 -> iq_valid, iq_full, iq_count go 0 immediately, without a clock edge.
